// File: rtl/zxuno_regbus_ctrl.sv
// ZXUNO extended-register bus sequencer: decodes Z80 I/O cycles on the select/data
// ports into register strobes and merges peripheral read data onto one CPU bus.
module zxuno_regbus_ctrl #(
  parameter logic [15:0] ADDR_PORT = 16'hFC3B,
  parameter logic [15:0] DATA_PORT = 16'hFD3B,
  parameter int          NPER      = 8,
  parameter logic [7:0]  IDLE_DATA = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       a,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_oe_n,
  output logic [7:0]        zxuno_addr,
  output logic              zxuno_regrd,
  output logic              zxuno_regwr,
  output logic [7:0]        zxuno_wdata,
  output logic              regaddr_changed,
  input  logic [8*NPER-1:0] per_dout,
  input  logic [NPER-1:0]   per_oe_n,
  output logic              collision
);

  logic       w_wa, w_wd, w_ra, w_rd;
  logic [7:0] w_sel;
  logic       w_multi;

  logic       r_wa_q, r_wd_q;
  logic [7:0] r_addr, r_wdata;
  logic       r_regrd, r_regwr, r_changed, r_coll;

  // Lowest-index enabled peripheral wins; IDLE_DATA when nobody drives.
  function automatic logic [7:0] f_prio_sel(input logic [8*NPER-1:0] dout,
                                            input logic [NPER-1:0]   oe_n);
    logic [7:0] sel;
    sel = IDLE_DATA;
    for (int i = NPER - 1; i >= 0; i--)
      if (!oe_n[i]) sel = dout[8*i +: 8];
    return sel;
  endfunction

  function automatic logic f_multi_drive(input logic [NPER-1:0] oe_n);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < NPER; i++)
      if (!oe_n[i]) cnt = cnt + 5'd1;
    return (cnt >= 5'd2);
  endfunction

  assign w_wa    = !iorq_n && !wr_n && (a == ADDR_PORT);
  assign w_wd    = !iorq_n && !wr_n && (a == DATA_PORT);
  assign w_ra    = !iorq_n && !rd_n && (a == ADDR_PORT);
  assign w_rd    = !iorq_n && !rd_n && (a == DATA_PORT);
  assign w_sel   = f_prio_sel(per_dout, per_oe_n);
  assign w_multi = f_multi_drive(per_oe_n);

  always_comb begin
    cpu_oe_n = 1'b1;
    cpu_dout = IDLE_DATA;
    if (w_ra) begin
      cpu_oe_n = 1'b0;
      cpu_dout = r_addr;
    end else if (w_rd && r_regrd) begin
      cpu_oe_n = 1'b0;
      cpu_dout = w_sel;
    end
  end

  // Edge registers reset high so a write still in progress at reset release is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wa_q    <= 1'b1;
      r_wd_q    <= 1'b1;
      r_addr    <= 8'h00;
      r_wdata   <= 8'h00;
      r_regrd   <= 1'b0;
      r_regwr   <= 1'b0;
      r_changed <= 1'b0;
      r_coll    <= 1'b0;
    end else begin
      r_wa_q    <= w_wa;
      r_wd_q    <= w_wd;
      r_regrd   <= w_rd;
      r_changed <= w_wa && !r_wa_q;
      r_regwr   <= w_wd && !r_wd_q;
      if (w_wa && !r_wa_q) r_addr <= cpu_din;
      if (w_wd && !r_wd_q) r_wdata <= cpu_din;
      if (r_regrd && w_multi) r_coll <= 1'b1;
    end
  end

  assign zxuno_addr      = r_addr;
  assign zxuno_wdata     = r_wdata;
  assign zxuno_regrd     = r_regrd;
  assign zxuno_regwr     = r_regwr;
  assign regaddr_changed = r_changed;
  assign collision       = r_coll;

endmodule
